// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write lanes,
// pending scoreboard and FSM-driven clear sweep. Define REGFILE_BYPASS_EN for write-to-read bypass.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     clr_req,
  output logic                     clr_busy
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                         state_q;
  logic [ADDR_W-1:0]              cnt_q;
  logic                           clr_busy_q;
  logic [DEPTH-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic [DEPTH-1:0]               pend_q, pend_d;
  logic                           idle, wr0_ok, wr1_ok, sb_ok, byp_en;

  assign idle   = (state_q == IDLE);
  assign wr0_ok = idle && we0 && (ZERO_REG == 0 || wa0 != '0);
  assign wr1_ok = idle && we1 && (ZERO_REG == 0 || wa1 != '0);
  assign sb_ok  = idle && sb_set && (ZERO_REG == 0 || sb_addr != '0);
  assign byp_en = BYPASS && !reset;

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (!idle) begin
      regs_d[cnt_q] = '0;
    end else begin
      // lane 1 assigned last so it wins an address collision
      if (wr0_ok) regs_d[wa0] = wd0;
      if (wr1_ok) regs_d[wa1] = wd1;
      if (wr0_ok) pend_d[wa0] = 1'b0;
      if (wr1_ok) pend_d[wa1] = 1'b0;
      if (clr_req)    pend_d = '0;
      else if (sb_ok) pend_d[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (clr_req) begin
          state_q    <= CLEAR;
          cnt_q      <= '0;
          clr_busy_q <= 1'b1;
        end
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (&cnt_q) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_busy = clr_busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic              hit0, hit1;
    logic [DATA_W-1:0] rd_k;
    logic              pend_k;

    assign ra_k = ra[k*ADDR_W +: ADDR_W];
    assign hit0 = byp_en && wr0_ok && (wa0 == ra_k);
    assign hit1 = byp_en && wr1_ok && (wa1 == ra_k);

    always_comb begin
      rd_k   = regs_q[ra_k];
      pend_k = pend_q[ra_k];
      if (ZERO_REG != 0 && ra_k == '0) begin
        rd_k   = '0;
        pend_k = 1'b0;
      end else if (hit1) begin
        rd_k   = wd1;
        pend_k = 1'b0;
      end else if (hit0) begin
        rd_k   = wd0;
        pend_k = 1'b0;
      end
    end

    assign rd[k*DATA_W +: DATA_W] = rd_k;
    assign rd_pend[k]             = pend_k;
  end

endmodule
